// File: rtl/video_stream_out.sv
// Pixel-stream-to-raster stage: buffers a valid/ready RGB stream in a small FIFO
// and replays it onto a free-running DVI raster once a start-of-frame beat lines up.
module video_stream_out #(
  parameter int   H_ACTIVE     = 640,
  parameter int   H_FRONT      = 16,
  parameter int   H_SYNC       = 96,
  parameter int   H_BACK       = 48,
  parameter int   V_ACTIVE     = 480,
  parameter int   V_FRONT      = 10,
  parameter int   V_SYNC       = 2,
  parameter int   V_BACK       = 33,
  parameter logic HSYNC_ACTIVE = 1'b0,
  parameter logic VSYNC_ACTIVE = 1'b0,
  parameter int   FIFO_DEPTH   = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [23:0] s_data,
  input  logic        s_user,
  output logic        video_de,
  output logic        video_hsync,
  output logic        video_vsync,
  output logic [23:0] video_data,
  output logic        locked,
  output logic        underflow,
  output logic        sof_error
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hCnt_q, hCnt_d;
  logic [VW-1:0] vCnt_q, vCnt_d;
  logic [AW:0]   wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [24:0]   mem_q [FIFO_DEPTH];
  logic          de_q, hsync_q, vsync_q;
  logic [23:0]   data_q, data_d;
  logic          underflow_q, underflow_d, sofError_q, sofError_d;

  logic          hLast, vLast, active, hs, vs, atOrigin;
  logic          full, empty, accept, push, popOk, flush, fault;
  logic [AW:0]   fill;
  logic [AW-1:0] wrAddr;
  logic [24:0]   head;

  assign hLast    = (hCnt_q == HW'(H_TOTAL - 1));
  assign vLast    = (vCnt_q == VW'(V_TOTAL - 1));
  assign active   = (int'(hCnt_q) < H_ACTIVE) && (int'(vCnt_q) < V_ACTIVE);
  assign hs       = (int'(hCnt_q) >= H_ACTIVE + H_FRONT) && (int'(hCnt_q) < H_ACTIVE + H_FRONT + H_SYNC);
  assign vs       = (int'(vCnt_q) >= V_ACTIVE + V_FRONT) && (int'(vCnt_q) < V_ACTIVE + V_FRONT + V_SYNC);
  assign atOrigin = (hCnt_q == '0) && (vCnt_q == '0);

  assign fill   = wrPtr_q - rdPtr_q;
  assign full   = (fill == (AW+1)'(FIFO_DEPTH));
  assign empty  = (wrPtr_q == rdPtr_q);
  assign head   = mem_q[rdPtr_q[AW-1:0]];
  assign s_ready = (state_q == IDLE) || !full;
  assign accept = s_valid && s_ready;

  assign hCnt_d = hLast ? '0 : hCnt_q + 1'b1;
  assign vCnt_d = hLast ? (vLast ? '0 : vCnt_q + 1'b1) : vCnt_q;

  always_comb begin
    state_d     = state_q;
    push        = 1'b0;
    popOk       = 1'b0;
    flush       = 1'b0;
    fault       = 1'b0;
    underflow_d = underflow_q;
    sofError_d  = sofError_q;
    case (state_q)
      IDLE: begin
        flush = 1'b1;
        if (accept && s_user) begin
          push    = 1'b1;
          state_d = ARMED;
        end
      end
      ARMED: begin
        push = accept;
        if (hLast && vLast) state_d = RUN;
      end
      RUN: begin
        push = accept;
        if (active) begin
          if (empty) begin
            fault       = 1'b1;
            underflow_d = 1'b1;
          end else if (head[24] != atOrigin) begin
            fault      = 1'b1;
            sofError_d = 1'b1;
          end else begin
            popOk = 1'b1;
          end
        end
        // A fault drops back to IDLE, so the beat accepted now follows IDLE rules.
        if (fault) begin
          flush   = 1'b1;
          push    = accept && s_user;
          state_d = push ? ARMED : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      wrPtr_d = push ? (AW+1)'(1) : '0;
      rdPtr_d = '0;
    end else begin
      wrPtr_d = wrPtr_q + {{AW{1'b0}}, push};
      rdPtr_d = rdPtr_q + {{AW{1'b0}}, popOk};
    end
    wrAddr = flush ? '0 : wrPtr_q[AW-1:0];
    data_d = popOk ? head[23:0] : 24'h0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      hCnt_q      <= '0;
      vCnt_q      <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      de_q        <= 1'b0;
      hsync_q     <= ~HSYNC_ACTIVE;
      vsync_q     <= ~VSYNC_ACTIVE;
      data_q      <= 24'h0;
      underflow_q <= 1'b0;
      sofError_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hCnt_q      <= hCnt_d;
      vCnt_q      <= vCnt_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      de_q        <= active;
      hsync_q     <= hs ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
      vsync_q     <= vs ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
      data_q      <= data_d;
      underflow_q <= underflow_d;
      sofError_q  <= sofError_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[wrAddr] <= {s_user, s_data};
  end

  assign video_de    = de_q;
  assign video_hsync = hsync_q;
  assign video_vsync = vsync_q;
  assign video_data  = data_q;
  assign locked      = (state_q == RUN);
  assign underflow   = underflow_q;
  assign sof_error   = sofError_q;

endmodule

// File: tb/tb_video_stream_out.sv
// Directed scenario sequence with random pixel payloads, checked every cycle against
// a queue-based stream model whose raster position comes from the cycle count.
module tb_video_stream_out;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2, HT = HA + HF + HS + HB;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1, VT = VA + VF + VS + VB;
  localparam int DEPTH = 4;

  logic        clock = 1'b0, reset = 1'b0;
  logic        sValid = 1'b0, sUser = 1'b0;
  logic [23:0] sData = 24'h0;
  logic        sReady, videoDe, videoHsync, videoVsync, locked, underflow, sofError;
  logic [23:0] videoData;

  video_stream_out #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_ACTIVE(1'b0), .VSYNC_ACTIVE(1'b0), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset),
    .s_valid(sValid), .s_ready(sReady), .s_data(sData), .s_user(sUser),
    .video_de(videoDe), .video_hsync(videoHsync), .video_vsync(videoVsync),
    .video_data(videoData), .locked(locked), .underflow(underflow), .sof_error(sofError)
  );

  always #5 clock = ~clock;

  typedef enum {M_IDLE, M_ARMED, M_RUN} mode_t;

  mode_t       mMode;
  int          tCnt;
  logic [24:0] modelQ[$];
  logic [24:0] srcQ[$];
  logic        expReady, expDe, expHs, expVs, expLocked, expUnder, expSof;
  logic [23:0] expData;
  bit          gapOn;
  int          checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s at pos %0d: observed=%0h expected=%0h", tag, tCnt, obs, exp);
    end
  endtask

  task automatic modelReset();
    mMode = M_IDLE;
    tCnt = 0;
    modelQ.delete();
    expUnder = 1'b0; expSof = 1'b0; expLocked = 1'b0;
    expDe = 1'b0; expHs = 1'b1; expVs = 1'b1; expData = 24'h0;
  endtask

  // The raster position is simply the number of clocks since reset, folded by the totals.
  task automatic modelStep(input logic vIn, input logic uIn, input logic [23:0] dIn, output logic acc);
    int h, v;
    bit act, origin, bad;
    logic [24:0] beat;
    h = tCnt % HT;
    v = (tCnt / HT) % VT;
    act = (h < HA) && (v < VA);
    origin = (h == 0) && (v == 0);
    expReady = (mMode == M_IDLE) ? 1'b1 : (modelQ.size() < DEPTH);
    acc = vIn && expReady;
    expData = 24'h0;
    bad = 1'b0;
    case (mMode)
      M_IDLE: if (acc && uIn) begin modelQ.push_back({uIn, dIn}); mMode = M_ARMED; end
      M_ARMED: begin
        if (acc) modelQ.push_back({uIn, dIn});
        if (h == HT - 1 && v == VT - 1) mMode = M_RUN;
      end
      default: begin
        if (act) begin
          if (modelQ.size() == 0) begin bad = 1'b1; expUnder = 1'b1; end
          else begin
            beat = modelQ.pop_front();
            if (beat[24] != origin) begin bad = 1'b1; expSof = 1'b1; end
            else expData = beat[23:0];
          end
        end
        if (bad) begin
          modelQ.delete();
          mMode = M_IDLE;
          if (acc && uIn) begin modelQ.push_back({uIn, dIn}); mMode = M_ARMED; end
        end else if (acc) modelQ.push_back({uIn, dIn});
      end
    endcase
    expDe = act;
    expHs = !((h >= HA + HF) && (h < HA + HF + HS));
    expVs = !((v >= VA + VF) && (v < VA + VF + VS));
    expLocked = (mMode == M_RUN);
    tCnt++;
  endtask

  task automatic checkOutput();
    check("video_de", videoDe, expDe);
    check("video_hsync", videoHsync, expHs);
    check("video_vsync", videoVsync, expVs);
    check("video_data", videoData, expData);
    check("locked", locked, expLocked);
    check("underflow", underflow, expUnder);
    check("sof_error", sofError, expSof);
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_de"}, videoDe, 1'b0);
    check({tag, "_hsync"}, videoHsync, 1'b1);
    check({tag, "_vsync"}, videoVsync, 1'b1);
    check({tag, "_data"}, videoData, 24'h0);
    check({tag, "_locked"}, locked, 1'b0);
    check({tag, "_underflow"}, underflow, 1'b0);
    check({tag, "_sof_error"}, sofError, 1'b0);
    check({tag, "_s_ready"}, sReady, 1'b1);
  endtask

  // One clock: drive inputs just after a falling edge, check s_ready, then the registered outputs.
  task automatic applyStimulus();
    logic vIn, uIn, acc;
    logic [23:0] dIn;
    vIn = (srcQ.size() > 0);
    if (vIn && gapOn && mMode != M_RUN && $urandom_range(0, 3) == 0) vIn = 1'b0;
    uIn = vIn ? srcQ[0][24] : 1'b0;
    dIn = vIn ? srcQ[0][23:0] : 24'h0;
    sValid = vIn; sUser = uIn; sData = dIn;
    modelStep(vIn, uIn, dIn, acc);
    #1;
    check("s_ready", sReady, expReady);
    if (acc) void'(srcQ.pop_front());
    @(posedge clock);
    @(negedge clock);
    checkOutput();
  endtask

  task automatic runTo(input int target);
    while (tCnt < target) applyStimulus();
  endtask

  task automatic queueFrame(input int n, input int extraSof);
    logic u;
    for (int i = 0; i < n; i++) begin
      u = (i == 0) || (i == extraSof);
      srcQ.push_back({u, 24'($urandom)});
    end
  endtask

  initial begin
    modelReset();
    gapOn = 1'b0;
    #1 reset = 1'b1;
    #2 checkReset("por");
    @(negedge clock);
    reset = 1'b0;

    runTo(100);
    // Frames A and B lock and display; frame C stops after pixel 19 and underflows.
    queueFrame(32, -1);
    queueFrame(32, -1);
    queueFrame(20, -1);
    runTo(430);

    // Frame D relocks, frame E carries a stray start flag at pixel 5, frame F relocks.
    queueFrame(32, -1);
    queueFrame(32, 5);
    queueFrame(32, -1);
    runTo(716);
    check("locked_before_reset", locked, 1'b1);

    #2 reset = 1'b1;
    #1 checkReset("mid");
    @(negedge clock);
    reset = 1'b0;
    modelReset();
    srcQ.delete();

    runTo(110);
    gapOn = 1'b1;
    queueFrame(32, -1);
    queueFrame(32, -1);
    queueFrame(32, -1);
    runTo(430);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_stream_out.md
Name: video_stream_out

Overview:
- Pixel-stream-to-raster stage that sits directly upstream of dvi_out, in the clock_dvi domain.
- Accepts a valid/ready RGB pixel stream with a start-of-frame flag and buffers it in a small FIFO.
- Generates the video timing raster and emits video_de/video_hsync/video_vsync/video_data for the TMDS encoder.
- Replaces the free-running pattern generator when real pixel sources (frame buffer reader, UART loader) drive the display.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_ACTIVE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BACK, 33, vertical back porch (lines)
HSYNC_ACTIVE, 1'b0, asserted level of video_hsync
VSYNC_ACTIVE, 1'b0, asserted level of video_vsync
FIFO_DEPTH, 16, pixel FIFO entries; power of two, >=2

Ports:
clock  in  1  pixel clock (clock_dvi)
reset  in  1  asynchronous, active-high reset
s_valid  in  1  input pixel valid
s_ready  out  1  input pixel accepted when s_valid&&s_ready
s_data  in  24  pixel {R,G,B}
s_user  in  1  start of frame; high on the first pixel of a frame
video_de  out  1  data enable to dvi_out
video_hsync  out  1  hsync to dvi_out
video_vsync  out  1  vsync to dvi_out
video_data  out  24  pixel to dvi_out
locked  out  1  high while in RUN
underflow  out  1  sticky: FIFO empty during an active pixel in RUN
sof_error  out  1  sticky: s_user misplaced in RUN

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high.
- Reset (async, any time): h_cnt=v_cnt=0, FIFO emptied, state=IDLE, locked=0, underflow=0, sof_error=0, video_de=0, video_data=0, video_hsync=~HSYNC_ACTIVE, video_vsync=~VSYNC_ACTIVE.
- Timing counters:
  - H_TOTAL = sum of the four H parameters; V_TOTAL likewise.
  - h_cnt wraps at H_TOTAL-1. v_cnt increments at h wrap and wraps at V_TOTAL-1.
  - Counters free-run from reset regardless of state.
- Raster regions (combinational from counters):
  - active = (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE).
  - hs = h_cnt in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC).
  - vs = v_cnt in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC).
- Outputs are registered: 1-cycle latency from counters.
  - video_de = active.
  - Each sync output is at its ACTIVE level when hs/vs is true.
  - video_data = popped pixel when active&&RUN&&!fault, else 24'h0.
- FIFO: stores {s_user, s_data}.
  - Push on s_valid&&s_ready.
  - Pop only in RUN on active cycles.
  - Simultaneous push and pop are allowed.
- Input handshake:
  - s_ready = 1 in IDLE.
  - s_ready = !full in ARMED/RUN; a pop in the same cycle does not raise s_ready.
- FSM:
  - IDLE:
    - FIFO held empty.
    - Accepted beats with s_user=0 are discarded.
    - A beat with s_user=1 is pushed and the FSM goes to ARMED.
  - ARMED:
    - Accepts into the FIFO.
    - Goes to RUN in the cycle where h_cnt==H_TOTAL-1 && v_cnt==V_TOTAL-1.
    - The next active pixel (0,0) is therefore the SOF beat.
  - RUN: each active cycle pops one entry.
    - Empty FIFO on an active cycle: set underflow, output 0, go to IDLE (flush).
    - Popped user=0 at pixel (0,0): set sof_error, output 0, go to IDLE.
    - Popped user=1 at any other active pixel: set sof_error, output 0, go to IDLE.
  - Entering IDLE flushes the FIFO in the same cycle.
  - An input beat accepted in that cycle is handled under IDLE rules.
- Timing is unaffected by faults: de/hsync/vsync continue, data is black until re-lock.
- Sticky flags clear only on reset.

Test Plan:
Sim params: H=8/2/2/2 (H_TOTAL=14), V=4/1/1/1 (V_TOTAL=7), FIFO_DEPTH=4, syncs active-low.
1. Reset, no input:
   - video_de high for 8 cycles in each of lines 0–3, data=0.
   - video_hsync low 2 cycles per line, starting 1 cycle after h_cnt=10.
   - video_vsync low during line 5.
   - Frame period 98 cycles; locked=0; s_ready=1.
2. Lock:
   - Stream pixels 0..31 continuously, s_user on pixel 0.
   - locked rises on the first frame boundary.
   - That frame outputs 0..7, 8..15, 16..23, 24..31 on de.
   - underflow=0, sof_error=0.
3. Backpressure:
   - Hold s_valid=1 in ARMED.
   - s_ready drops after 4 accepts.
   - No beat is lost or duplicated across a full frame.
4. Underflow:
   - Stop supplying after pixel 19.
   - Pixel slot 20 onward outputs 0.
   - underflow=1, locked=0, s_ready=1; re-locks on the next s_user beat.
5. SOF error:
   - s_user=1 on pixel 5 in RUN.
   - Slot 5 outputs 0, sof_error=1, state IDLE.
   - Re-locks at the following frame boundary.
6. Async reset mid-frame (RUN, v_cnt=2):
   - Outputs immediately take reset values; flags clear.
   - Counters restart at 0.
